// File: rtl/cpu_mem_arbiter.sv
// Registered three-way memory bus controller: mem stage, instruction fetch and DMA
// share one external port through an IDLE -> ACCESS -> DONE sequence.
module cpu_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int WAIT_MAX     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mreq_i,
  input  logic          freq_i,
  input  logic          dreq_i,
  input  logic [AW-1:0] maddr_i,
  input  logic [AW-1:0] faddr_i,
  input  logic [AW-1:0] daddr_i,
  input  logic          mwe_i,
  input  logic          dwe_i,
  input  logic [DW-1:0] mwdata_i,
  input  logic [DW-1:0] dwdata_i,
  output logic          mack_o,
  output logic          fack_o,
  output logic          dack_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic [AW-1:0] addr_o,
  output logic          re_o,
  output logic          we_o,
  output logic [DW-1:0] data_o,
  output logic          data_oe_o,
  input  logic [DW-1:0] data_i,
  input  logic          needWait_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    owner;  // one-hot {dma, fetch, mem} of the latched winner
  logic          any_req, starved, gnt_m, gnt_f, gnt_d, timeout_hit;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    any_req     = mreq_i | freq_i | dreq_i;
    starved     = dreq_i && (starve_cnt == SW'(STARVE_LIMIT));
    gnt_m       = !starved && mreq_i;
    gnt_f       = !starved && !mreq_i && freq_i;
    gnt_d       = starved || (dreq_i && !mreq_i && !freq_i);
    sel_addr    = daddr_i;
    sel_we      = dwe_i;
    sel_wdata   = dwdata_i;
    if (gnt_m) begin
      sel_addr  = maddr_i;
      sel_we    = mwe_i;
      sel_wdata = mwdata_i;
    end else if (gnt_f) begin
      sel_addr  = faddr_i;
      sel_we    = 1'b0;
      sel_wdata = '0;
    end
    timeout_hit = needWait_i && (wait_cnt == WW'(WAIT_MAX - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (!needWait_i || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wait_cnt   <= '0;
      owner      <= '0;
      addr_o     <= '0;
      re_o       <= 1'b0;
      we_o       <= 1'b0;
      data_o     <= '0;
      data_oe_o  <= 1'b0;
      mack_o     <= 1'b0;
      fack_o     <= 1'b0;
      dack_o     <= 1'b0;
      err_o      <= 1'b0;
      rdata_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= {gnt_d, gnt_f, gnt_m};
            addr_o    <= sel_addr;
            re_o      <= !sel_we;
            we_o      <= sel_we;
            data_o    <= sel_wdata;
            data_oe_o <= sel_we;
          end
          if (gnt_d)
            starve_cnt <= '0;
          else if (dreq_i && starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SW'(1);
        end
        ACCESS: begin
          wait_cnt <= needWait_i ? wait_cnt + WW'(1) : '0;
          // we_o still holds the latched direction while the access is on the bus
          if (!needWait_i || timeout_hit) begin
            if (!needWait_i && !we_o) rdata_o <= data_i;
            {dack_o, fack_o, mack_o} <= owner;
            err_o     <= needWait_i;
            addr_o    <= '0;
            re_o      <= 1'b0;
            we_o      <= 1'b0;
            data_o    <= '0;
            data_oe_o <= 1'b0;
          end
        end
        DONE: begin
          mack_o   <= 1'b0;
          fack_o   <= 1'b0;
          dack_o   <= 1'b0;
          err_o    <= 1'b0;
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
